instruction_decode: RTL and testbench

Pipeline stage directly downstream of instruction fetch. It takes one fetched RV32I instruction per cycle, decodes it into register indices, an immediate, an instruction class and exception information, and holds the result in a single pipeline register for the execute stage. It propagates stall upstream, inserts bubbles, and squashes its contents on a pipeline flush.

---
 rtl/instruction_decode.sv | 221 ++++++++++++++++++++++
 tb/tb_instruction_decode.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
//
// RV32I decode stage sitting directly after instruction fetch. Each cycle it
// decodes one fetched instruction into register indices/enables, a
// sign-extended immediate, an instruction class and trap information, and
// holds the result in one pipeline register for the execute stage.
//
// Optional feature macro: RV32M_EN
//   defined   : OP with funct7 = 0x01 decodes as class 11 (MULDIV)
//   undefined : that encoding is an illegal instruction (cause 2)
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   if_inst, if_pc        instruction word and its PC from fetch
//   if_valid              fetch inputs carry a live instruction
//   if_exception_num/valid fetch-side exception cause / flag
//   flush                 squash held and incoming instruction
//   stall                 execute cannot accept; hold the register
//   if_stall              stall forwarded to fetch (combinational)
//   de_*                  registered decode result for execute
// -----------------------------------------------------------------------------
module instruction_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  input  logic        if_valid,
  input  logic [5:0]  if_exception_num,
  input  logic        if_exception_valid,
  input  logic        flush,
  input  logic        stall,
  output logic        if_stall,
  output logic        de_valid,
  output logic [31:0] de_pc,
  output logic [31:0] de_inst,
  output logic [3:0]  de_class,
  output logic [2:0]  de_funct3,
  output logic        de_alt,
  output logic [4:0]  de_rd,
  output logic [4:0]  de_rs1,
  output logic [4:0]  de_rs2,
  output logic        de_rd_en,
  output logic        de_rs1_en,
  output logic        de_rs2_en,
  output logic [31:0] de_imm,
  output logic [5:0]  de_exception_num,
  output logic        de_exception_valid
);

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [3:0] CL_LUI     = 4'd0;
  localparam logic [3:0] CL_AUIPC   = 4'd1;
  localparam logic [3:0] CL_JAL     = 4'd2;
  localparam logic [3:0] CL_JALR    = 4'd3;
  localparam logic [3:0] CL_BRANCH  = 4'd4;
  localparam logic [3:0] CL_LOAD    = 4'd5;
  localparam logic [3:0] CL_STORE   = 4'd6;
  localparam logic [3:0] CL_OPIMM   = 4'd7;
  localparam logic [3:0] CL_OP      = 4'd8;
  localparam logic [3:0] CL_MISCMEM = 4'd9;
  localparam logic [3:0] CL_SYSTEM  = 4'd10;
`ifdef RV32M_EN
  localparam logic [3:0] CL_MULDIV  = 4'd11;
`endif

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = if_inst[6:0];
  assign funct3 = if_inst[14:12];
  assign funct7 = if_inst[31:25];

  // Pre-computed immediate formats; bit 31 always sign-extends
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{if_inst[31]}}, if_inst[31:20]};
  assign imm_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
  assign imm_b = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
  assign imm_u = {if_inst[31:12], 12'b0};
  assign imm_j = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};

  logic [3:0]  class_d;
  logic [31:0] imm_d;
  logic        alt_d, illegal_d, rs1_use, rs2_use, rd_use;
  logic        exc_d, rd_en_d, rs1_en_d, rs2_en_d;
  logic [5:0]  exc_num_d;
  logic        is_ecall, is_ebreak;

  assign is_ecall  = (if_inst == 32'h0000_0073);
  assign is_ebreak = (if_inst == 32'h0010_0073);

  always_comb begin
    class_d   = CL_LUI;
    imm_d     = 32'b0;
    alt_d     = 1'b0;
    illegal_d = 1'b0;
    rs1_use   = 1'b0;
    rs2_use   = 1'b0;
    rd_use    = 1'b0;
    case (opcode)
      OPC_LUI:   begin class_d = CL_LUI;   imm_d = imm_u; rd_use = 1'b1; end
      OPC_AUIPC: begin class_d = CL_AUIPC; imm_d = imm_u; rd_use = 1'b1; end
      OPC_JAL:   begin class_d = CL_JAL;   imm_d = imm_j; rd_use = 1'b1; end
      OPC_JALR: begin
        class_d = CL_JALR; imm_d = imm_i; rs1_use = 1'b1; rd_use = 1'b1;
        illegal_d = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        class_d = CL_BRANCH; imm_d = imm_b; rs1_use = 1'b1; rs2_use = 1'b1;
        illegal_d = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_LOAD: begin
        class_d = CL_LOAD; imm_d = imm_i; rs1_use = 1'b1; rd_use = 1'b1;
        illegal_d = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        class_d = CL_STORE; imm_d = imm_s; rs1_use = 1'b1; rs2_use = 1'b1;
        illegal_d = (funct3 > 3'd2);
      end
      OPC_OPIMM: begin
        class_d = CL_OPIMM; imm_d = imm_i; rs1_use = 1'b1; rd_use = 1'b1;
        // Shifts carry funct7 in the immediate; only SRAI may set bit 30
        if (funct3 == 3'd1) begin
          illegal_d = (funct7 != 7'h00);
          alt_d     = if_inst[30];
        end else if (funct3 == 3'd5) begin
          illegal_d = (funct7 != 7'h00) && (funct7 != 7'h20);
          alt_d     = if_inst[30];
        end
      end
      OPC_OP: begin
        rs1_use = 1'b1; rs2_use = 1'b1; rd_use = 1'b1;
        if (funct7 == 7'h01) begin
`ifdef RV32M_EN
          class_d = CL_MULDIV;
`else
          class_d   = CL_OP;
          illegal_d = 1'b1;
`endif
        end else begin
          class_d   = CL_OP;
          alt_d     = if_inst[30];
          illegal_d = ((funct7 != 7'h00) && (funct7 != 7'h20)) ||
                      ((funct7 == 7'h20) && (funct3 != 3'd0) && (funct3 != 3'd5));
        end
      end
      OPC_MISCMEM: class_d = CL_MISCMEM;
      OPC_SYSTEM: begin class_d = CL_SYSTEM; imm_d = imm_i; end
      default:   illegal_d = 1'b1;
    endcase
    if (if_inst[1:0] != 2'b11) illegal_d = 1'b1;
  end

  // Trap priority: fetch fault, then illegal, then ECALL/EBREAK
  always_comb begin
    exc_d     = 1'b1;
    exc_num_d = 6'd0;
    if (if_exception_valid)  exc_num_d = if_exception_num;
    else if (illegal_d)      exc_num_d = 6'd2;
    else if (is_ecall)       exc_num_d = 6'd11;
    else if (is_ebreak)      exc_num_d = 6'd3;
    else                     exc_d     = 1'b0;
  end

  // A trapping instruction reads and writes no registers
  assign rs1_en_d = rs1_use & ~exc_d;
  assign rs2_en_d = rs2_use & ~exc_d;
  assign rd_en_d  = rd_use & ~exc_d & (if_inst[11:7] != 5'd0);

  assign if_stall = stall;

  // ---- decode -> execute pipeline register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      de_valid           <= 1'b0;
      de_pc              <= 32'b0;
      de_inst            <= 32'b0;
      de_class           <= 4'b0;
      de_funct3          <= 3'b0;
      de_alt             <= 1'b0;
      de_rd              <= 5'b0;
      de_rs1             <= 5'b0;
      de_rs2             <= 5'b0;
      de_rd_en           <= 1'b0;
      de_rs1_en          <= 1'b0;
      de_rs2_en          <= 1'b0;
      de_imm             <= 32'b0;
      de_exception_num   <= 6'b0;
      de_exception_valid <= 1'b0;
    end else if (flush || !stall) begin
      // Flush overrides stall: the slot is loaded but marked dead
      de_valid           <= if_valid & ~flush;
      de_pc              <= if_pc;
      de_inst            <= if_inst;
      de_class           <= class_d;
      de_funct3          <= funct3;
      de_alt             <= alt_d;
      de_rd              <= if_inst[11:7];
      de_rs1             <= if_inst[19:15];
      de_rs2             <= if_inst[24:20];
      de_rd_en           <= rd_en_d;
      de_rs1_en          <= rs1_en_d;
      de_rs2_en          <= rs2_en_d;
      de_imm             <= imm_d;
      de_exception_num   <= exc_num_d;
      de_exception_valid <= exc_d & if_valid & ~flush;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_inst, if_pc;
  logic        if_valid;
  logic [5:0]  if_exception_num;
  logic        if_exception_valid;
  logic        flush, stall;
  logic        if_stall;
  logic        de_valid;
  logic [31:0] de_pc, de_inst, de_imm;
  logic [3:0]  de_class;
  logic [2:0]  de_funct3;
  logic        de_alt;
  logic [4:0]  de_rd, de_rs1, de_rs2;
  logic        de_rd_en, de_rs1_en, de_rs2_en;
  logic [5:0]  de_exception_num;
  logic        de_exception_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruction_decode dut (
    .clk                (clk),
    .reset              (reset),
    .if_inst            (if_inst),
    .if_pc              (if_pc),
    .if_valid           (if_valid),
    .if_exception_num   (if_exception_num),
    .if_exception_valid (if_exception_valid),
    .flush              (flush),
    .stall              (stall),
    .if_stall           (if_stall),
    .de_valid           (de_valid),
    .de_pc              (de_pc),
    .de_inst            (de_inst),
    .de_class           (de_class),
    .de_funct3          (de_funct3),
    .de_alt             (de_alt),
    .de_rd              (de_rd),
    .de_rs1             (de_rs1),
    .de_rs2             (de_rs2),
    .de_rd_en           (de_rd_en),
    .de_rs1_en          (de_rs1_en),
    .de_rs2_en          (de_rs2_en),
    .de_imm             (de_imm),
    .de_exception_num   (de_exception_num),
    .de_exception_valid (de_exception_valid)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic v,
                       input logic exv, input logic [5:0] exn);
    if_inst            = inst;
    if_pc              = pc;
    if_valid           = v;
    if_exception_valid = exv;
    if_exception_num   = exn;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    step(); step();
    check_vec("rst_valid", {31'b0, de_valid}, 32'd0);
    check_vec("rst_pc", de_pc, 32'd0);
    check_vec("rst_inst", de_inst, 32'd0);
    check_vec("rst_excv", {31'b0, de_exception_valid}, 32'd0);
    reset = 1'b0;

    // addi x1,x0,5
    drive(32'h0050_0093, 32'h100, 1'b1, 1'b0, 6'd0);
    step();
    check_vec("addi_valid", {31'b0, de_valid}, 32'd1);
    check_vec("addi_class", {28'b0, de_class}, 32'd7);
    check_vec("addi_rd", {27'b0, de_rd}, 32'd1);
    check_vec("addi_rd_en", {31'b0, de_rd_en}, 32'd1);
    check_vec("addi_rs1", {27'b0, de_rs1}, 32'd0);
    check_vec("addi_rs1_en", {31'b0, de_rs1_en}, 32'd1);
    check_vec("addi_rs2_en", {31'b0, de_rs2_en}, 32'd0);
    check_vec("addi_imm", de_imm, 32'd5);
    check_vec("addi_pc", de_pc, 32'h100);
    check_vec("addi_excv", {31'b0, de_exception_valid}, 32'd0);

    // beq x0,x0,-4
    drive(32'hFE00_0EE3, 32'h104, 1'b1, 1'b0, 6'd0);
    step();
    check_vec("beq_class", {28'b0, de_class}, 32'd4);
    check_vec("beq_imm", de_imm, 32'hFFFF_FFFC);
    check_vec("beq_rd_en", {31'b0, de_rd_en}, 32'd0);
    check_vec("beq_rs_en", {30'b0, de_rs1_en, de_rs2_en}, 32'd3);

    // lui x1,0x12345
    drive(32'h1234_50B7, 32'h108, 1'b1, 1'b0, 6'd0);
    step();
    check_vec("lui_class", {28'b0, de_class}, 32'd0);
    check_vec("lui_imm", de_imm, 32'h1234_5000);
    check_vec("lui_en", {29'b0, de_rd_en, de_rs1_en, de_rs2_en}, 32'b100);

    // sw x2,8(x1)
    drive(32'h0020_A423, 32'h10C, 1'b1, 1'b0, 6'd0);
    step();
    check_vec("sw_class", {28'b0, de_class}, 32'd6);
    check_vec("sw_imm", de_imm, 32'd8);
    check_vec("sw_en", {29'b0, de_rd_en, de_rs1_en, de_rs2_en}, 32'b011);
    check_vec("sw_funct3", {29'b0, de_funct3}, 32'd2);

    // srai x3,x1,2
    drive(32'h4020_D193, 32'h110, 1'b1, 1'b0, 6'd0);
    step();
    check_vec("srai_class", {28'b0, de_class}, 32'd7);
    check_vec("srai_alt", {31'b0, de_alt}, 32'd1);
    check_vec("srai_excv", {31'b0, de_exception_valid}, 32'd0);
    check_vec("srai_imm", de_imm, 32'h402);

    // all-ones word is illegal
    drive(32'hFFFF_FFFF, 32'h114, 1'b1, 1'b0, 6'd0);
    step();
    check_vec("ill_valid", {31'b0, de_valid}, 32'd1);
    check_vec("ill_excv", {31'b0, de_exception_valid}, 32'd1);
    check_vec("ill_num", {26'b0, de_exception_num}, 32'd2);
    check_vec("ill_en", {29'b0, de_rd_en, de_rs1_en, de_rs2_en}, 32'b000);

    // fetch exception outranks illegal
    drive(32'hFFFF_FFFF, 32'h118, 1'b1, 1'b1, 6'd1);
    step();
    check_vec("fexc_num", {26'b0, de_exception_num}, 32'd1);
    check_vec("fexc_excv", {31'b0, de_exception_valid}, 32'd1);

    // branch funct3 = 2 is illegal
    drive(32'h0000_2063, 32'h11C, 1'b1, 1'b0, 6'd0);
    step();
    check_vec("br3_num", {26'b0, de_exception_num}, 32'd2);
    check_vec("br3_excv", {31'b0, de_exception_valid}, 32'd1);

    // bubble
    drive(32'h0050_0093, 32'h120, 1'b0, 1'b0, 6'd0);
    step();
    check_vec("bubble_valid", {31'b0, de_valid}, 32'd0);

    // stall holds the register for 3 cycles
    drive(32'h0050_0093, 32'h100, 1'b1, 1'b0, 6'd0);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0020_A423 + i, 32'h200 + i, 1'b1, 1'b0, 6'd0);
      #1;
      check_vec("stall_ifstall", {31'b0, if_stall}, 32'd1);
      step();
      check_vec("stall_inst", de_inst, 32'h0050_0093);
      check_vec("stall_pc", de_pc, 32'h100);
      check_vec("stall_valid", {31'b0, de_valid}, 32'd1);
    end
    flush = 1'b1;
    step();
    check_vec("flush_stall_valid", {31'b0, de_valid}, 32'd0);
    stall = 1'b0;

    // flush squashes an incoming illegal instruction
    drive(32'hFFFF_FFFF, 32'h300, 1'b1, 1'b0, 6'd0);
    step();
    check_vec("flush_valid", {31'b0, de_valid}, 32'd0);
    check_vec("flush_excv", {31'b0, de_exception_valid}, 32'd0);
    flush = 1'b0;
    #1;
    check_vec("ifstall_low", {31'b0, if_stall}, 32'd0);

    // mul x0,x1,x2
    drive(32'h0220_8033, 32'h304, 1'b1, 1'b0, 6'd0);
    step();
`ifdef RV32M_EN
    check_vec("mul_class", {28'b0, de_class}, 32'd11);
    check_vec("mul_en", {29'b0, de_rd_en, de_rs1_en, de_rs2_en}, 32'b011);
    check_vec("mul_excv", {31'b0, de_exception_valid}, 32'd0);
`else
    check_vec("mul_excv", {31'b0, de_exception_valid}, 32'd1);
    check_vec("mul_num", {26'b0, de_exception_num}, 32'd2);
`endif

    // ECALL / EBREAK
    drive(32'h0000_0073, 32'h308, 1'b1, 1'b0, 6'd0);
    step();
    check_vec("ecall_num", {26'b0, de_exception_num}, 32'd11);
    check_vec("ecall_class", {28'b0, de_class}, 32'd10);
    check_vec("ecall_excv", {31'b0, de_exception_valid}, 32'd1);
    drive(32'h0010_0073, 32'h30C, 1'b1, 1'b0, 6'd0);
    step();
    check_vec("ebreak_num", {26'b0, de_exception_num}, 32'd3);
    check_vec("ebreak_excv", {31'b0, de_exception_valid}, 32'd1);

    // reset mid-stream beats stall and flush
    drive(32'h1234_50B7, 32'h400, 1'b1, 1'b0, 6'd0);
    step();
    reset = 1'b1; stall = 1'b1; flush = 1'b1;
    step();
    check_vec("mrst_valid", {31'b0, de_valid}, 32'd0);
    check_vec("mrst_pc", de_pc, 32'd0);
    check_vec("mrst_inst", de_inst, 32'd0);
    check_vec("mrst_imm", de_imm, 32'd0);
    check_vec("mrst_rd", {27'b0, de_rd}, 32'd0);
    check_vec("mrst_en", {29'b0, de_rd_en, de_rs1_en, de_rs2_en}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
